// File: rtl/decoder4_seq_if.sv
// -----------------------------------------------------------------------------
// decoder4_seq_if
// Bundles the code-input handshake and the decoded outputs of decoder4_seq.
//
// Signals:
//   in_valid  a code is presented on y1,y0
//   y1, y0    2-bit code (y1 = MSB)
//   in_ready  the decoder can accept a code this cycle
//   a0..a3    one-hot decoded lines (a0 = code 0)
//   busy      decoder is not idle
//   done      one-cycle pulse on the last drive cycle
//   cnt       8-bit wrapping count of accepted codes
//
// Modports:
//   master    code producer (drives in_valid, y1, y0)
//   slave     the decoder itself
// -----------------------------------------------------------------------------
interface decoder4_seq_if;
    logic       in_valid;
    logic       y1;
    logic       y0;
    logic       in_ready;
    logic       a0;
    logic       a1;
    logic       a2;
    logic       a3;
    logic       busy;
    logic       done;
    logic [7:0] cnt;

    modport master (
        output in_valid, y1, y0,
        input  in_ready, a0, a1, a2, a3, busy, done, cnt
    );

    modport slave (
        input  in_valid, y1, y0,
        output in_ready, a0, a1, a2, a3, busy, done, cnt
    );
endinterface

// File: rtl/decoder4_seq.sv
// -----------------------------------------------------------------------------
// decoder4_seq
// Sequenced 2-to-4 decoder. A code accepted in IDLE is latched and its one-hot
// line is driven for HOLD cycles (DRIVE), followed by GAP all-zero cycles (GAP),
// then the block returns to IDLE where it can accept the next code.
//
// Parameters:
//   HOLD  cycles the one-hot line is driven, 1..255
//   GAP   all-zero cycles after each drive window, 0..255
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    decoder4_seq_if.slave: in_valid/y1/y0 in; in_ready, a0..a3,
//          busy, done, cnt out
// -----------------------------------------------------------------------------
module decoder4_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder4_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t     state,      state_next;
    logic [7:0] hold_cnt,   hold_next;
    logic [7:0] gap_cnt,    gap_next;
    logic [1:0] code,       code_next;
    logic [7:0] cnt,        cnt_next;
    logic [3:0] lines,      lines_next;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= 8'd0;
            gap_cnt  <= 8'd0;
            code     <= 2'b00;
            cnt      <= 8'd0;
            lines    <= 4'b0000;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            gap_cnt  <= gap_next;
            code     <= code_next;
            cnt      <= cnt_next;
            lines    <= lines_next;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        gap_next   = gap_cnt;
        code_next  = code;
        cnt_next   = cnt;

        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_next = ST_DRIVE;
                    hold_next  = HOLD_LOAD;
                    code_next  = {bus.y1, bus.y0};
                    cnt_next   = cnt + 8'd1;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt == 8'd0) begin
                    if (GAP > 0) begin
                        state_next = ST_GAP;
                        gap_next   = GAP_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    hold_next = hold_cnt - 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_cnt - 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Lines are registered from the next state so they rise in the first
        // DRIVE cycle and fall in the first cycle after it, with no path from
        // the code inputs to the outputs.
        lines_next = (state_next == ST_DRIVE) ? onehot(code_next) : 4'b0000;
    end

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DRIVE) && (hold_cnt == 8'd0);
    assign bus.cnt      = cnt;
    assign bus.a0       = lines[0];
    assign bus.a1       = lines[1];
    assign bus.a2       = lines[2];
    assign bus.a3       = lines[3];

endmodule

// File: tb/tb_decoder4_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder4_seq
// Scoreboard bench for decoder4_seq. Stimulus pushes one expected drive window
// (code, length, done count, cnt) per acceptance; a negedge monitor measures
// each drive window on dut_a and compares it to the queue head. dut_b runs the
// HOLD=1, GAP=0 configuration with directed per-cycle checks.
// -----------------------------------------------------------------------------
module tb_decoder4_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    decoder4_seq_if ifa ();
    decoder4_seq_if ifb ();

    decoder4_seq #(.HOLD(4), .GAP(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    decoder4_seq #(.HOLD(1), .GAP(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef struct {
        int code;
        int len;
        int ndone;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int code, input int len, input int nd, input int c);
        exp_t e;
        e.code  = code;
        e.len   = len;
        e.ndone = nd;
        e.cnt   = c;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ifa.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready=%b required 1", ifa.in_ready);
        end
    endtask

    // Present one code for exactly one accepting edge. With scramble set, y1/y0
    // are flipped on every DRIVE cycle while in_valid stays high.
    task automatic send(input int code, input bit scramble);
        logic [1:0] yv;
        wait_ready();
        yv = code[1:0];
        ifa.in_valid = 1'b1;
        {ifa.y1, ifa.y0} = yv;
        exp_cnt = (exp_cnt + 1) % 256;
        push(code, 4, 1, exp_cnt);
        tick();
        if (scramble) begin
            for (int i = 0; i < 4; i++) begin
                yv = ~yv ^ 2'(i);
                {ifa.y1, ifa.y0} = yv;
                tick();
            end
        end
        ifa.in_valid = 1'b0;
    endtask

    // Drive-window monitor for dut_a
    logic [3:0] cur_a;
    logic [3:0] first_pat;
    int         run_len  = 0;
    int         ndone    = 0;
    int         last_done = 0;
    int         pat_err  = 0;
    exp_t       e_mon;

    always @(negedge clk) begin
        if (mon_en) begin
            cur_a = {ifa.a3, ifa.a2, ifa.a1, ifa.a0};
            if (cur_a != 4'b0000) begin
                if (run_len == 0) first_pat = cur_a;
                else if (cur_a != first_pat) pat_err = 1;
                run_len++;
                ndone    += int'(ifa.done);
                last_done = int'(ifa.done);
            end else if (run_len != 0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL win_unexpected: window pattern %b with empty queue", first_pat);
                end else begin
                    e_mon = sb.pop_front();
                    check("win_onehot",    int'(first_pat), 1 << e_mon.code);
                    check("win_steady",    pat_err, 0);
                    check("win_len",       run_len, e_mon.len);
                    check("win_done",      ndone, e_mon.ndone);
                    check("win_done_last", last_done, (e_mon.ndone > 0) ? 1 : 0);
                    check("win_cnt",       int'(ifa.cnt), e_mon.cnt);
                end
                run_len   = 0;
                ndone     = 0;
                last_done = 0;
                pat_err   = 0;
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.y1       = 1'b1;
        ifa.y0       = 1'b1;
        ifb.in_valid = 1'b0;
        ifb.y1       = 1'b0;
        ifb.y0       = 1'b0;

        // Reset with in_valid high: nothing must be accepted
        tick();
        tick();
        check("rst_lines", int'({ifa.a3, ifa.a2, ifa.a1, ifa.a0}), 0);
        check("rst_busy",  int'(ifa.busy), 0);
        check("rst_done",  int'(ifa.done), 0);
        check("rst_cnt",   int'(ifa.cnt), 0);
        check("rst_ready", int'(ifa.in_ready), 1);
        check("rst_busy_b", int'(ifb.busy), 0);
        ifa.in_valid = 1'b0;
        rst_n        = 1'b1;
        mon_en       = 1'b1;
        tick();
        check("post_rst_ready", int'(ifa.in_ready), 1);
        check("post_rst_cnt",   int'(ifa.cnt), 0);

        // Each code in turn
        for (int c = 0; c < 4; c++) send(c, 1'b0);
        wait_ready();
        check("cnt_after_4", int'(ifa.cnt), 4);

        // Inputs scrambled during DRIVE of code 01
        send(1, 1'b1);
        wait_ready();
        check("cnt_after_scramble", int'(ifa.cnt), 5);

        // Continuous in_valid with code 10: acceptances every 6 cycles
        ifa.in_valid = 1'b1;
        {ifa.y1, ifa.y0} = 2'b10;
        for (int i = 0; i < 18; i++) begin
            check("ready_cont", int'(ifa.in_ready), (i % 6 == 0) ? 1 : 0);
            if (i % 6 == 0) begin
                exp_cnt = (exp_cnt + 1) % 256;
                push(2, 4, 1, exp_cnt);
            end
            tick();
        end
        ifa.in_valid = 1'b0;
        check("ready_after_cont", int'(ifa.in_ready), 1);
        check("cnt_after_cont",   int'(ifa.cnt), 8);

        // Reset in the second DRIVE cycle of code 01
        wait_ready();
        ifa.in_valid = 1'b1;
        {ifa.y1, ifa.y0} = 2'b01;
        push(1, 2, 0, 0);
        tick();
        ifa.in_valid = 1'b0;
        tick();
        check("abort_in_drive", int'(ifa.a1), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        check("abort_lines", int'({ifa.a3, ifa.a2, ifa.a1, ifa.a0}), 0);
        check("abort_busy",  int'(ifa.busy), 0);
        check("abort_done",  int'(ifa.done), 0);
        check("abort_cnt",   int'(ifa.cnt), 0);
        check("abort_ready", int'(ifa.in_ready), 1);

        // 257 acceptances: cnt wraps to 1
        ifa.in_valid = 1'b1;
        {ifa.y1, ifa.y0} = 2'b00;
        for (int i = 0; i < 257 * 6; i++) begin
            if (i % 6 == 0) begin
                exp_cnt = (exp_cnt + 1) % 256;
                push(0, 4, 1, exp_cnt);
            end
            tick();
        end
        ifa.in_valid = 1'b0;
        wait_ready();
        tick();
        check("cnt_wrap", int'(ifa.cnt), 1);

        // HOLD=1, GAP=0 with continuous code 11
        ifb.in_valid = 1'b1;
        {ifb.y1, ifb.y0} = 2'b11;
        for (int i = 0; i < 10; i++) begin
            check("b_ready", int'(ifb.in_ready), (i % 2 == 0) ? 1 : 0);
            check("b_lines", int'({ifb.a3, ifb.a2, ifb.a1, ifb.a0}), (i % 2 == 1) ? 8 : 0);
            check("b_done",  int'(ifb.done), (i % 2 == 1) ? 1 : 0);
            tick();
        end
        ifb.in_valid = 1'b0;
        tick();
        tick();
        check("b_cnt", int'(ifb.cnt), 5);

        tick();
        tick();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on the whole run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded", $time);
        $fatal(1, "timeout");
    end

endmodule
